// File: rtl/bcd_counter_n.sv
// Multi-digit BCD counter with synchronous load, invalid-nibble detection and ripple carry.
// Define BCD_COUNTER_DOWN_EN to add the `down` port and bidirectional counting.
module bcd_counter_n #(
    parameter int unsigned           DIGITS      = 4,
    parameter logic [4*DIGITS-1:0]   RESET_VALUE = '0
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset_n,
    input  logic                  tick_in,
`ifdef BCD_COUNTER_DOWN_EN
    input  logic                  down,
`endif
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick_out,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                load_err_q, load_err_d;

    logic [4*DIGITS-1:0] count_step;
    logic [4*DIGITS-1:0] load_clean;
    logic                load_bad;
    logic                all_nine;
    logic                carry;
    logic [3:0]          digit;
`ifdef BCD_COUNTER_DOWN_EN
    logic                all_zero;
`endif

    // Ripple carry/borrow across every digit in a single cycle.
    always_comb begin
        count_step = count_q;
        carry      = tick_in;
        all_nine   = 1'b1;
        digit      = '0;
`ifdef BCD_COUNTER_DOWN_EN
        all_zero   = 1'b1;
`endif
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit    = count_q[4*i +: 4];
            all_nine = all_nine & (digit == 4'd9);
`ifdef BCD_COUNTER_DOWN_EN
            all_zero = all_zero & (digit == 4'd0);
            if (carry) begin
                if (down) begin
                    if (digit == 4'd0) begin
                        count_step[4*i +: 4] = 4'd9;
                    end else begin
                        count_step[4*i +: 4] = digit - 4'd1;
                        carry                = 1'b0;
                    end
                end else begin
                    if (digit >= 4'd9) begin
                        count_step[4*i +: 4] = 4'd0;
                    end else begin
                        count_step[4*i +: 4] = digit + 4'd1;
                        carry                = 1'b0;
                    end
                end
            end
`else
            if (carry) begin
                if (digit >= 4'd9) begin
                    count_step[4*i +: 4] = 4'd0;
                end else begin
                    count_step[4*i +: 4] = digit + 4'd1;
                    carry                = 1'b0;
                end
            end
`endif
        end
    end

    // Non-BCD nibbles load as zero and raise the error flag.
    always_comb begin
        load_clean = '0;
        load_bad   = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_value[4*i +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_clean[4*i +: 4] = load_value[4*i +: 4];
            end
        end
    end

    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        if (load) begin
            count_d    = load_clean;
            load_err_d = load_bad;
        end else if (tick_in) begin
            count_d    = count_step;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            count_q    <= RESET_VALUE;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
`ifdef BCD_COUNTER_DOWN_EN
        tick_out = tick_in & ~load & (down ? all_zero : all_nine);
`else
        tick_out = tick_in & ~load & all_nine;
`endif
    end

    assign count    = count_q;
    assign load_err = load_err_q;

endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised multi-digit BCD counter: a chain of DIGITS decimal digits that advances by one on each `tick_in` strobe, with synchronous parallel load, invalid-digit detection and an optional down-count mode. It generalises the single-digit BCD stage into a complete decimal counter for display, timer and event-count paths. `tick_out` chains further counters or triggers downstream logic.

## Interface
- `DIGITS`, default 4: number of BCD digits, legal range 1..8; count width is 4*DIGITS.
- `RESET_VALUE`, default 0: BCD-encoded value applied on reset; must contain only digits 0..9.
- `sys_clk`  in  1  system clock; all state changes on the rising edge.
- `sys_reset_n`  in  1  asynchronous, active-low reset.
- `tick_in`  in  1  count strobe, one count per cycle it is high.
- `down`  in  1  count direction: 0 = up, 1 = down. Present only with BCD_COUNTER_DOWN_EN.
- `load`  in  1  synchronous parallel load request.
- `load_value`  in  4*DIGITS  BCD value to load; digit i occupies bits [4i+3:4i].
- `count`  out  4*DIGITS  registered BCD count; digit 0 is least significant.
- `tick_out`  out  1  terminal-count strobe for cascading (combinational).
- `load_err`  out  1  registered one-cycle flag: the last load contained a non-BCD nibble.

## Operation
- Reset (`sys_reset_n`=0, any time, asynchronous): `count` = RESET_VALUE, `load_err` = 0. `tick_out` follows its equation from the reset count. Reset mid-count or mid-load discards the pending update.
- Priority per cycle: reset > load > tick.
- Load (`load`=1): each nibble 0..9 is copied to its digit. Each nibble 10..15 loads 0 into that digit. `load_err` = 1 in the following cycle if any nibble was invalid, else 0. `tick_in` is ignored in a load cycle.
- Up count (`tick_in`=1, `load`=0, direction up): digit 0 increments. A digit at 9 wraps to 0 and carries into the next digit. Ripple carry is resolved within one cycle. Only digits whose lower digits are all 9 change.
- Down count (direction down): digit 0 decrements. A digit at 0 wraps to 9 and borrows from the next digit.
- Terminal wrap: up from all-9s gives all-0s; down from all-0s gives all-9s.
- `tick_out` = `tick_in` & !`load` & (count is all-9s when up, all-0s when down). It is high exactly in the cycle before the counter wraps.
- No tick, no load: `count` holds; `load_err` returns to 0 after one cycle.
- Nibbles of `count` are always in 0..9 after reset.

## Timing
- Latency: `count` reflects a tick or load at the first rising edge after it is sampled high, i.e. a 1-cycle update.
- `tick_out`: combinational, same cycle as the qualifying `tick_in`. There is no registered delay, so cascaded counters advance on the same edge.
- `load_err`: valid for exactly the one cycle after the load edge.
- Back-to-back ticks on every cycle are supported; the counter advances once per cycle.
- `down` is sampled together with `tick_in`; a direction change takes effect on that edge.

## Configuration
- `BCD_COUNTER_DOWN_EN` defined: the `down` port exists and bidirectional counting is as described above.
- Not defined: the `down` port is absent, the counter counts up only, and `tick_out` uses the all-9s condition only. The down/borrow logic is not synthesised.

## Test plan
- Reset: DIGITS=4, RESET_VALUE=16'h0042, hold `sys_reset_n`=0 for 2 clocks → `count`=16'h0042, `load_err`=0. Release, then 15 ticks → `count`=16'h0057.
- Carry ripple: load 16'h0999, then 1 tick → `count`=16'h1000. `tick_out` stays 0 throughout.
- Terminal wrap: load 16'h9999, drive `tick_in`=1 → `tick_out`=1 in that cycle. Next edge gives `count`=16'h0000, and `tick_out`=0 in the following cycle.
- Invalid load: `load_value`=16'h3A7F → `count`=16'h3070, `load_err`=1 for one cycle, then 0. Repeat with `load`=1 and `tick_in`=1 together → load wins and no tick is counted.
- Down count (macro defined): load 16'h1000, `down`=1, 1 tick → 16'h0999. Load 16'h0000 with `tick_in`=1 → `tick_out`=1, then `count`=16'h9999.
- Async reset mid-operation: tick every cycle from 16'h0000, assert `sys_reset_n`=0 between edges after 7 ticks → `count` immediately equals RESET_VALUE with no clock edge, and holds until reset is released.
